// File: rtl/divider16x8.sv
// Sequential unsigned restoring divider, 16-bit dividend / 8-bit divisor, one quotient bit per clock.
// Optional feature: define DIV_ZERO_CHECK_EN to short-circuit divide-by-zero (2-cycle latency, dbz flag).
module divider16x8 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        busy,
  output logic        done,
  output logic        dbz,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic [15:0] shift_q;      // dividend bits shift out the top, quotient bits shift in the bottom
  logic [7:0]  dvs_q;
  logic [7:0]  rem_q;
  logic [3:0]  cnt_q;
  logic [15:0] quotient_q;
  logic [7:0]  remainder_q;
  logic        busy_q;
  logic        done_q;
`ifdef DIV_ZERO_CHECK_EN
  logic        zero_q;
  logic        dbz_q;
`endif

  logic [8:0]  rem_shift_d;
  logic        take_d;
  logic [7:0]  rem_d;
  logic [15:0] shift_d;

  // Handshake: start is sampled only when busy=0 (IDLE or DONE); busy stays high
  // for the whole iteration, then done pulses for one cycle with results valid.
  always_comb begin
    rem_shift_d = {rem_q, shift_q[15]};
    take_d      = (rem_shift_d >= {1'b0, dvs_q});
    // A successful trial always leaves a value below the divisor, so the low byte is exact.
    rem_d       = take_d ? (rem_shift_d[7:0] - dvs_q) : rem_shift_d[7:0];
    shift_d     = {shift_q[14:0], take_d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      shift_q     <= 16'h0000;
      dvs_q       <= 8'h00;
      rem_q       <= 8'h00;
      cnt_q       <= 4'h0;
      quotient_q  <= 16'h0000;
      remainder_q <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            shift_q <= dividend;
            dvs_q   <= divisor;
            rem_q   <= 8'h00;
            cnt_q   <= 4'h0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
`ifdef DIV_ZERO_CHECK_EN
            zero_q  <= (divisor == 8'h00);
`endif
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
`ifdef DIV_ZERO_CHECK_EN
          if (zero_q) begin
            quotient_q  <= 16'hFFFF;
            remainder_q <= shift_q[7:0];
            dbz_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end else begin
`else
          begin
`endif
            shift_q <= shift_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_q + 4'h1;
            if (cnt_q == 4'hF) begin
              quotient_q  <= shift_d;
              remainder_q <= rem_d;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= S_DONE;
`ifdef DIV_ZERO_CHECK_EN
              dbz_q       <= 1'b0;
`endif
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;
`ifdef DIV_ZERO_CHECK_EN
  assign dbz = dbz_q;
`else
  assign dbz = 1'b0;
`endif

endmodule

// File: tb/tb_divider16x8.sv
// Bench for divider16x8: table vectors, hand sequences for busy/reset corners, random sweep.
module tb_divider16x8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = 16'h0000;
  logic [7:0]  divisor = 8'h00;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
  logic        dbz;
  logic [1:0]  dbg_state;

`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  divider16x8 dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .dbz         (dbz),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  // {start_cyc[31:0], latency[7:0], dbz, quotient[15:0], remainder[7:0]}
  logic [64:0] exp_q[$];
  logic [64:0] mon_e;
  logic        prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (done) begin
      check("done_width", {31'b0, prev_done}, 32'd0);
      check("busy_at_done", {31'b0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("quotient", {16'b0, quotient}, {16'b0, mon_e[23:8]});
        check("remainder", {24'b0, remainder}, {24'b0, mon_e[7:0]});
        check("dbz", {31'b0, dbz}, {31'b0, mon_e[24]});
        check("latency", cyc - mon_e[64:33], {24'b0, mon_e[32:25]});
      end
    end
    prev_done = done;
  end

  // ---------------- driver tasks ----------------
  task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                       input logic [15:0] eq, input logic [7:0] er);
    int k;
    logic       zdet;
    logic [7:0] lat;
    k = 0;
    @(negedge clk);
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      check("wait_idle_timeout", {31'b0, busy}, 32'd0);
      return;
    end
    zdet = ZC && (b == 8'h00);
    lat  = zdet ? 8'd2 : 8'd17;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    exp_q.push_back({cyc[31:0], lat, zdet, eq, er});
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    check("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_quotient"}, {16'b0, quotient}, 32'd0);
    check({tag, "_remainder"}, {24'b0, remainder}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_dbz"}, {31'b0, dbz}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;

    tbl[0] = '{16'h03E8, 8'h07, 16'h008E, 8'h06};
    tbl[1] = '{16'hFFFF, 8'hFF, 16'h0101, 8'h00};
    tbl[2] = '{16'h0005, 8'h09, 16'h0000, 8'h05};
    tbl[3] = '{16'h1234, 8'h00, 16'hFFFF, 8'h34};
    tbl[4] = '{16'h0064, 8'h0A, 16'h000A, 8'h00};
    tbl[5] = '{16'h0000, 8'h01, 16'h0000, 8'h00};
    tbl[6] = '{16'hFFFF, 8'h01, 16'hFFFF, 8'h00};
    tbl[7] = '{16'h00FF, 8'h10, 16'h000F, 8'h0F};
    tbl[8] = '{16'h8000, 8'h80, 16'h0100, 8'h00};
    tbl[9] = '{16'hFFFF, 8'h02, 16'h7FFF, 8'h01};

    #1;
    check_outputs_zero("reset");
    check("reset_state", {30'b0, dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r);
      if (i % 3 == 0) drain();
    end
    drain();

    // start pulses with fresh operands mid-run must be ignored
    do_op(16'h03E8, 8'h07, 16'h008E, 8'h06);
    repeat (3) @(negedge clk);
    start = 1'b1; dividend = 16'hBEEF; divisor = 8'h03;
    check("busy_mid_run_a", {31'b0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 16'h0100; divisor = 8'h00;
    check("busy_mid_run_b", {31'b0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    drain();

    // back-to-back: second start lands in the done cycle
    do_op(16'hFFFF, 8'hFF, 16'h0101, 8'h00);
    do_op(16'h0005, 8'h09, 16'h0000, 8'h05);
    drain();

    // asynchronous reset mid-operation
    do_op(16'h03E8, 8'h07, 16'h008E, 8'h06);
    repeat (6) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_outputs_zero("midrun_reset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("no_done_after_reset", {31'b0, done}, 32'd0);
    end
    do_op(16'h0064, 8'h0A, 16'h000A, 8'h00);
    drain();

    // random sweep against a / b, a % b
    for (int i = 0; i < 2000; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      if (rb == 8'h00) do_op(ra, rb, 16'hFFFF, ra[7:0]);
      else             do_op(ra, rb, ra / {8'h00, rb}, 8'(ra % {8'h00, rb}));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
